// File: rtl/sm_fetch.sv
// sm_fetch: instruction fetch stage for the pipelined schoolRISCV core.
// Drives a combinational instruction ROM, queues {pc, instr} pairs in a small
// in-order buffer and hands the head to decode over a valid/ready handshake.
module sm_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] im_addr,
   input  logic [31:0] im_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [31:0]      r_fetch_pc;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [31:0]      r_pc_mem    [DEPTH];
   logic [31:0]      r_instr_mem [DEPTH];

   logic w_pop;
   logic w_push;
   logic w_empty;

   // Handshake qualifiers; redirect suppresses any push in its cycle.
   always_comb begin
      w_empty = (r_count == '0);
      w_pop   = ~w_empty & id_ready;
      w_push  = fetch_en & ~redirect & ((r_count < CNT_W'(DEPTH)) | w_pop);
   end

   // Fetch PC: redirect wins, otherwise advance by one word on each push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect) begin
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   // Buffer occupancy and pointers; redirect flushes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else if (redirect) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Buffer storage: capture the ROM word together with the PC it came from.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_pc_mem[i]    <= '0;
            r_instr_mem[i] <= NOP_INSTR;
         end
      end else if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
         r_instr_mem[r_wr_ptr] <= im_data;
      end
   end

   // Head presentation from stored state only; an empty buffer shows a NOP at pc 0.
   always_comb begin
      im_addr  = r_fetch_pc;
      id_valid = ~w_empty;
      id_instr = NOP_INSTR;
      id_pc    = '0;
      if (!w_empty) begin
         id_instr = r_instr_mem[r_rd_ptr];
         id_pc    = r_pc_mem[r_rd_ptr];
      end
   end

endmodule

// File: tb/tb_sm_fetch.sv
// tb_sm_fetch: directed and randomized checks of sm_fetch against a queue model.
module tb_sm_fetch;

   localparam int unsigned DEPTH     = 2;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] im_addr;
   logic [31:0] im_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   int checks = 0;
   int errors = 0;

   // Reference model: fetch address plus an ordered list of {pc, instr}.
   logic [63:0] mq [$];
   logic [31:0] m_pc;

   sm_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP_INSTR)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .im_addr(im_addr), .im_data(im_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_instr(id_instr), .id_pc(id_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return 32'h1000_0000 + (a / 32'd4);
   endfunction

   assign im_data = rom(im_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("im_addr",  im_addr, m_pc);
      chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
      chk("id_instr", id_instr, (mq.size() != 0) ? mq[0][31:0]  : NOP_INSTR);
      chk("id_pc",    id_pc,    (mq.size() != 0) ? mq[0][63:32] : 32'h0);
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc = RESET_PC;
   endtask

   // One clock: drive at the falling edge, check mid-low phase, update the model at the rising edge.
   task automatic cycle(input logic fe, input logic rdy, input logic rd, input logic [31:0] rpc);
      logic pop, push;
      fetch_en    = fe;
      id_ready    = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
      check_model();
      @(posedge clk);
      if (rd) begin
         mq.delete();
         m_pc = {rpc[31:2], 2'b00};
      end else begin
         pop  = (mq.size() != 0) && rdy;
         push = fe && ((mq.size() < int'(DEPTH)) || pop);
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back({m_pc, rom(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] hold_addr;
      rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_valid", 32'(id_valid), 32'h0);
      chk("reset_instr", id_instr, NOP_INSTR);
      chk("reset_pc", id_pc, 32'h0);
      chk("reset_addr", im_addr, RESET_PC);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming with decode always ready.
      repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
      chk("stream_lead", im_addr, id_pc + 32'd4);

      // Back-pressure: buffer saturates, fetch address holds.
      model_reset();
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      repeat (6) cycle(1'b1, 1'b0, 1'b0, '0);
      chk("sat_addr",  im_addr, 32'h8);
      chk("sat_pc",    id_pc, 32'h0);
      chk("sat_instr", id_instr, 32'h1000_0000);
      repeat (5) cycle(1'b1, 1'b1, 1'b0, '0);

      // Redirect on a full buffer.
      repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b1, 32'h42);
      chk("redir_addr", im_addr, 32'h40);
      chk("redir_valid", 32'(id_valid), 32'h0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      chk("redir_pc", id_pc, 32'h40);
      chk("redir_instr", id_instr, 32'h1000_0010);

      // Redirect with a same-cycle pop on two buffered entries.
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b1, 32'h100);
      chk("redir_pop_valid", 32'(id_valid), 32'h0);
      repeat (3) cycle(1'b1, 1'b1, 1'b0, '0);

      // Address wrap at the top of memory.
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      cycle(1'b1, 1'b1, 1'b0, '0);
      chk("wrap_pc0", id_pc, 32'hFFFF_FFFC);
      chk("wrap_addr0", im_addr, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, '0);
      chk("wrap_pc1", id_pc, 32'h0);
      chk("wrap_addr1", im_addr, 32'h4);

      // Asynchronous reset between edges with a full buffer.
      repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(id_valid), 32'h0);
      chk("async_instr", id_instr, NOP_INSTR);
      chk("async_addr", im_addr, RESET_PC);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);

      // fetch_en low: address holds while the buffer drains.
      hold_addr = im_addr;
      repeat (3) cycle(1'b0, 1'b1, 1'b0, '0);
      chk("halt_addr", im_addr, hold_addr);
      chk("halt_valid", 32'(id_valid), 32'h0);

      // Redirect while halted: nothing issues until fetch resumes.
      cycle(1'b0, 1'b1, 1'b1, 32'h203);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, '0);
      chk("halt_redir_addr", im_addr, 32'h200);
      repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), $urandom);
      end
      #1;
      check_model();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
